lbp: RTL and testbench

Loop branch predictor for the CVA6 frontend. It learns conditional branches that are taken a fixed number of times and then fall through once. For such branches it predicts the exit iteration exactly. It answers same-cycle lookups on the fetch PC and trains from resolved-branch updates on the bht-style update channel, acting as the responder the testbench driver and monitor exercise.

---
 rtl/lbp.sv | 177 +++++++++++++++++
 tb/tb_lbp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lbp.sv
// Loop branch predictor: learns branches taken a fixed number of times, then not taken once.
// Latency: lookup is combinational (0 cycles); an update is visible on the cycle after its edge.
// Backpressure: none; every update is absorbed in one cycle, and flush_i wins over a coincident update.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                invalidate every entry at the next edge
//   debug_mode_i           suppress training while high (lookups still answer)
//   vpc_i                  fetch PC to look up
//   upd_valid_i/_pc_i/_taken_i   resolved conditional branch
//   lbp_valid_o            confident hit on vpc_i
//   lbp_taken_o            predicted direction (hit and iteration not yet at trip count)
module lbp #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CNT_BITS   = 10,
  parameter int unsigned CONF_MAX   = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            debug_mode_i,
  input  logic [VLEN-1:0] vpc_i,
  input  logic            upd_valid_i,
  input  logic [VLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  output logic            lbp_valid_o,
  output logic            lbp_taken_o
);

  localparam int unsigned IDX_BITS = $clog2(NR_ENTRIES);
  localparam int unsigned TAG_HI   = IDX_BITS + TAG_BITS;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ZERO = '0;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [1:0]          CONF_TOP = 2'd3;
  localparam logic [1:0]          CONF_REQ = 2'(CONF_MAX);

  // Table state
  logic [NR_ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0]   tag_q  [NR_ENTRIES];
  logic [CNT_BITS-1:0]   trip_q [NR_ENTRIES];
  logic [CNT_BITS-1:0]   iter_q [NR_ENTRIES];
  logic [1:0]            conf_q [NR_ENTRIES];

  // Bit 0 is skipped so compressed and full-width branches share one index space.
  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;

  assign lk_idx = vpc_i[IDX_BITS:1];
  assign lk_tag = vpc_i[TAG_HI:IDX_BITS+1];
  assign up_idx = upd_pc_i[IDX_BITS:1];
  assign up_tag = upd_pc_i[TAG_HI:IDX_BITS+1];

  // High PC bits and bit 0 play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{vpc_i[VLEN-1:TAG_HI+1], vpc_i[0],
                            upd_pc_i[VLEN-1:TAG_HI+1], upd_pc_i[0]};

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  logic lk_hit;

  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    lbp_valid_o = lk_hit && (conf_q[lk_idx] == CONF_REQ);
    lbp_taken_o = lk_hit && (iter_q[lk_idx] != trip_q[lk_idx]);
  end

  // ---------------------------------------------------------------------------
  // Training: next state of the single entry addressed by the update
  // ---------------------------------------------------------------------------
  logic                cur_valid;
  logic [TAG_BITS-1:0] cur_tag;
  logic [CNT_BITS-1:0] cur_trip;
  logic [CNT_BITS-1:0] cur_iter;
  logic [1:0]          cur_conf;
  logic [CNT_BITS-1:0] iter_inc;
  logic                up_hit;
  logic                up_en;

  logic                we_d;
  logic                valid_d;
  logic [TAG_BITS-1:0] tag_d;
  logic [CNT_BITS-1:0] trip_d;
  logic [CNT_BITS-1:0] iter_d;
  logic [1:0]          conf_d;

  always_comb begin
    cur_valid = valid_q[up_idx];
    cur_tag   = tag_q[up_idx];
    cur_trip  = trip_q[up_idx];
    cur_iter  = iter_q[up_idx];
    cur_conf  = conf_q[up_idx];
    iter_inc  = cur_iter + CNT_ONE;
    up_hit    = cur_valid && (cur_tag == up_tag);
    up_en     = upd_valid_i && !debug_mode_i;

    we_d    = 1'b0;
    valid_d = cur_valid;
    tag_d   = cur_tag;
    trip_d  = cur_trip;
    iter_d  = cur_iter;
    conf_d  = cur_conf;

    if (up_en) begin
      if (up_hit) begin
        we_d = 1'b1;
        if (upd_taken_i) begin
          if (cur_iter == CNT_MAX) begin
            // Loop longer than the counter can represent: give up on it.
            valid_d = 1'b0;
          end else begin
            iter_d = iter_inc;
            // Ran past the learned exit: the trip count is stale.
            if ((cur_trip != CNT_ZERO) && (iter_inc > cur_trip)) begin
              trip_d = CNT_ZERO;
              conf_d = 2'd0;
            end
          end
        end else begin
          if (cur_iter == CNT_ZERO) begin
            // Fell through with no body iterations: not a loop branch.
            valid_d = 1'b0;
          end else begin
            if ((cur_trip != CNT_ZERO) && (cur_iter == cur_trip)) begin
              if (cur_conf != CONF_TOP) conf_d = cur_conf + 2'd1;
            end else begin
              trip_d = cur_iter;
              conf_d = 2'd0;
            end
            iter_d = CNT_ZERO;
          end
        end
      end else if (upd_taken_i) begin
        we_d = 1'b1;
        // A confident occupant is only worn down, so one stray branch
        // cannot evict a well-trained loop.
        if (!cur_valid || (cur_conf == 2'd0)) begin
          valid_d = 1'b1;
          tag_d   = up_tag;
          trip_d  = CNT_ZERO;
          iter_d  = CNT_ONE;
          conf_d  = 2'd0;
        end else begin
          conf_d = cur_conf - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        tag_q[i]  <= '0;
        trip_q[i] <= '0;
        iter_q[i] <= '0;
        conf_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_d) begin
      valid_q[up_idx] <= valid_d;
      tag_q[up_idx]   <= tag_d;
      trip_q[up_idx]  <= trip_d;
      iter_q[up_idx]  <= iter_d;
      conf_q[up_idx]  <= conf_d;
    end
  end

endmodule

// File: tb/tb_lbp.sv
module tb_lbp;

  localparam logic [63:0] PC_A = 64'h0000_0000_8000_0040; // idx 0, tag 2
  localparam logic [63:0] PC_B = 64'h0000_0000_8000_0060; // idx 0, tag 3
  localparam logic [63:0] PC_C = 64'h0000_0000_0000_0104; // idx 2, tag 8
  localparam logic [63:0] PC_S = 64'h0000_0000_0000_0200;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        dbg;
  logic [63:0] vpc;
  logic        upd_v;
  logic [63:0] upd_pc;
  logic        upd_t;
  logic        pv;
  logic        pt;

  logic        s_upd_v;
  logic        s_upd_t;
  logic [63:0] s_pc;
  logic        s_pv;
  logic        s_pt;

  int n_cmp = 0;
  int n_bad = 0;

  lbp u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .debug_mode_i (dbg),
    .vpc_i        (vpc),
    .upd_valid_i  (upd_v),
    .upd_pc_i     (upd_pc),
    .upd_taken_i  (upd_t),
    .lbp_valid_o  (pv),
    .lbp_taken_o  (pt)
  );

  // Narrow counters to reach iteration saturation quickly.
  lbp #(.CNT_BITS(4)) u_sat (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (1'b0),
    .debug_mode_i (1'b0),
    .vpc_i        (s_pc),
    .upd_valid_i  (s_upd_v),
    .upd_pc_i     (s_pc),
    .upd_taken_i  (s_upd_t),
    .lbp_valid_o  (s_pv),
    .lbp_taken_o  (s_pt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        uv;
    logic        ut;
    logic [63:0] pc;
    logic        fl;
    logic        db;
    logic        ev;
    logic        et;
  } vec_t;

  vec_t vecs[$];

  task automatic ad(input logic uv, input logic ut, input logic [63:0] pc,
                    input logic fl, input logic db, input logic ev, input logic et);
    vec_t v;
    v.uv = uv; v.ut = ut; v.pc = pc; v.fl = fl; v.db = db; v.ev = ev; v.et = et;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic av, input logic at,
                       input logic ev, input logic et);
    n_cmp++;
    if ((av !== ev) || (at !== et)) begin
      n_bad++;
      $display("FAIL %s: got valid=%b taken=%b, expected valid=%b taken=%b",
               name, av, at, ev, et);
    end
  endtask

  initial begin
    flush = 0; dbg = 0; vpc = PC_A; upd_v = 0; upd_pc = PC_A; upd_t = 0;
    s_upd_v = 0; s_upd_t = 0; s_pc = PC_S;
    rst_n = 0;

    // Table: each row is checked before its edge, so it shows pre-update state.
    ad(0,0,PC_A,0,0,0,0);                                  // reset state
    ad(1,1,PC_A,0,0,0,0); ad(1,1,PC_A,0,0,0,1);            // pattern 1 (allocate)
    ad(1,1,PC_A,0,0,0,1); ad(1,0,PC_A,0,0,0,1);
    for (int p = 0; p < 3; p++) begin                      // patterns 2..4: conf 1..3
      ad(1,1,PC_A,0,0,0,1); ad(1,1,PC_A,0,0,0,1); ad(1,1,PC_A,0,0,0,1);
      ad(1,0,PC_A,0,0,0,0);
    end
    ad(0,0,PC_A,0,0,1,1);                                  // confident now
    ad(1,1,PC_A,0,0,1,1); ad(1,1,PC_A,0,0,1,1);            // predicted pattern
    ad(1,1,PC_A,0,0,1,1); ad(1,0,PC_A,0,0,1,0);
    ad(1,1,PC_A,0,0,1,1); ad(1,1,PC_A,0,0,1,1);            // trip change T,T,N
    ad(1,0,PC_A,0,0,1,1);
    ad(0,0,PC_A,0,0,0,1);                                  // conf 0, trip 2
    for (int p = 0; p < 3; p++) begin                      // relearn trip 2
      ad(1,1,PC_A,0,0,0,1); ad(1,1,PC_A,0,0,0,1); ad(1,0,PC_A,0,0,0,0);
    end
    ad(0,0,PC_A,0,0,1,1);
    ad(1,1,PC_B,0,0,0,0);                                  // conflict: A conf 2
    ad(0,0,PC_A,0,0,0,1);
    ad(1,1,PC_B,0,0,0,0); ad(1,1,PC_B,0,0,0,0);            // A conf 1, 0
    ad(0,0,PC_A,0,0,0,1);
    ad(1,1,PC_B,0,0,0,0);                                  // B replaces A
    ad(0,0,PC_B,0,0,0,1); ad(0,0,PC_A,0,0,0,0);
    ad(1,0,PC_A,0,0,0,0);                                  // miss not-taken: no change
    ad(0,0,PC_B,0,0,0,1);
    ad(1,1,PC_C,0,0,0,0); ad(1,0,PC_C,0,0,0,1);            // learn trip 1 at C
    for (int p = 0; p < 3; p++) begin
      ad(1,1,PC_C,0,0,0,1); ad(1,0,PC_C,0,0,0,0);
    end
    ad(0,0,PC_C,0,0,1,1);
    ad(0,0,PC_C | 64'h1,0,0,1,1);                          // bit 0 ignored
    ad(1,1,PC_C,0,1,1,1); ad(0,0,PC_C,0,0,1,1);            // debug blocks T
    ad(1,0,PC_C,0,1,1,1); ad(0,0,PC_C,0,0,1,1);            // debug blocks N
    ad(1,1,PC_C,1,0,1,1);                                  // flush + update
    ad(0,0,PC_C,0,0,0,0); ad(0,0,PC_B,0,0,0,0);
    ad(1,1,PC_C,0,0,0,0); ad(1,0,PC_C,0,0,0,1);            // N with iter 0 invalidates
    ad(1,0,PC_C,0,0,0,1); ad(0,0,PC_C,0,0,0,0);

    // Initial reset, released away from a clock edge.
    #12;
    check("reset_hold", pv, pt, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      vpc = vecs[i].pc; upd_pc = vecs[i].pc;
      upd_v = vecs[i].uv; upd_t = vecs[i].ut;
      flush = vecs[i].fl; dbg = vecs[i].db;
      #1;
      check($sformatf("vec[%0d]", i), pv, pt, vecs[i].ev, vecs[i].et);
      @(posedge clk);
      #1;
      upd_v = 0; upd_t = 0; flush = 0; dbg = 0;
    end

    // Mid-training asynchronous reset.
    @(negedge clk);
    vpc = PC_A; upd_pc = PC_A; upd_v = 1; upd_t = 1;
    @(posedge clk);
    #1 upd_v = 0;
    #1 check("pre_async_reset", pv, pt, 1'b0, 1'b1);
    #1 rst_n = 0;
    #1 check("async_reset_now", pv, pt, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1;
    #1 check("after_reset_release", pv, pt, 1'b0, 1'b0);
    vpc = PC_C;
    #1 check("after_reset_other_pc", pv, pt, 1'b0, 1'b0);

    // Iteration counter saturation with 4-bit counters.
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      s_pc = PC_S; s_upd_v = 1; s_upd_t = 1;
      #1 check($sformatf("sat_pre[%0d]", k), s_pv, s_pt, 1'b0, (k != 0));
      @(posedge clk);
      #1 s_upd_v = 0;
    end
    @(negedge clk);
    #1 check("sat_invalidated", s_pv, s_pt, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
